// File: rtl/control_pkg.sv
// control_pkg: shared definitions for the multicycle control unit.
//   - datapath/opcode widths
//   - opcode constants (ALU codes double as the ULA operation select)
//   - step-state encoding T0..T3
//   - instruction-register field positions
//   - helper that classifies an opcode as a ULA operation
package control_pkg;

    localparam int CU_DATA_W = 16;
    localparam int CU_OP_W   = 4;

    localparam logic [3:0] OP_MV   = 4'b0000;
    localparam logic [3:0] OP_MVI  = 4'b0001;
    localparam logic [3:0] OP_MVNZ = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    // Instruction word fields; bits [5:0] carry no meaning.
    localparam int IR_OP_HI = 15;
    localparam int IR_OP_LO = 12;
    localparam int IR_RX_HI = 11;
    localparam int IR_RX_LO = 9;
    localparam int IR_RY_HI = 8;
    localparam int IR_RY_LO = 6;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_OR) ||
               (op == OP_SLT) || (op == OP_SLL) || (op == OP_SRL);
    endfunction

endpackage

// File: rtl/dec3to8.sv
// dec3to8: 3-bit register index to 8-bit one-hot select with enable.
//   idx    in  3  register index
//   en     in  1  enable; output is all-zero when low
//   onehot out 8  one-hot select (bit idx set when en)
module dec3to8 (
    input  logic [2:0] idx,
    input  logic       en,
    output logic [7:0] onehot
);

    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
        assign onehot[gi] = en && (idx == 3'(gi));
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: multicycle control FSM for the 16-bit bus-based processor.
// Fetches an instruction from DIN in T0, then sequences register-file, A, G
// and bus-mux strobes over T1..T3. Strobes are decoded from the step state
// and the latched instruction.
//   Clock   in   1       system clock, rising edge
//   Resetn  in   1       synchronous active-low reset
//   Run     in   1       start request, looked at only in T0
//   DIN     in   DATA_W  instruction in T0, immediate in T1 of mvi
//   Gnz     in   1       G register is non-zero (mvnz condition)
//   sinal   out  OP_W    ULA operation select
//   Rin     out  8       one-hot write enable R0..R7
//   Rout    out  8       one-hot bus drive R0..R7
//   Ain     out  1       load A from bus
//   Gin     out  1       load G from ULA
//   Gout    out  1       G drives bus
//   DINout  out  1       DIN drives bus
//   Done    out  1       final step of an instruction
module control_unit
    import control_pkg::*;
#(
    parameter int DATA_W = CU_DATA_W,
    parameter int OP_W   = CU_OP_W
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    input  logic              Gnz,
    output logic [OP_W-1:0]   sinal,
    output logic [7:0]        Rin,
    output logic [7:0]        Rout,
    output logic              Ain,
    output logic              Gin,
    output logic              Gout,
    output logic              DINout,
    output logic              Done
);

    state_t      state_reg;
    // Only the meaningful instruction bits [15:6] are kept.
    logic [9:0]  ir_reg;
    logic        unused_din_bits;

    assign unused_din_bits = ^DIN[IR_RY_LO-1:0];

    logic [3:0]  op;
    logic [2:0]  rx;
    logic [2:0]  ry;

    assign op = ir_reg[IR_OP_HI-IR_RY_LO:IR_OP_LO-IR_RY_LO];
    assign rx = ir_reg[IR_RX_HI-IR_RY_LO:IR_RX_LO-IR_RY_LO];
    assign ry = ir_reg[IR_RY_HI-IR_RY_LO:0];

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_reg <= T0;
            ir_reg    <= '0;
        end else begin
            case (state_reg)
                T0: begin
                    if (Run) begin
                        ir_reg    <= DIN[IR_OP_HI:IR_RY_LO];
                        state_reg <= T1;
                    end
                end
                T1:      state_reg <= is_alu_op(op) ? T2 : T0;
                T2:      state_reg <= T3;
                default: state_reg <= T0;
            endcase
        end
    end

    logic       rin_en;
    logic       rout_en;
    logic [2:0] rin_sel;
    logic [2:0] rout_sel;

    // Everything stays low while Resetn is low because no state branch is taken.
    always_comb begin
        rin_en   = 1'b0;
        rout_en  = 1'b0;
        rin_sel  = rx;
        rout_sel = ry;
        Ain      = 1'b0;
        Gin      = 1'b0;
        Gout     = 1'b0;
        DINout   = 1'b0;
        Done     = 1'b0;
        sinal    = '0;
        if (Resetn) begin
            case (state_reg)
                T1: begin
                    if (op == OP_MV) begin
                        rout_en = 1'b1;
                        rin_en  = 1'b1;
                        Done    = 1'b1;
                    end else if (op == OP_MVI) begin
                        DINout  = 1'b1;
                        rin_en  = 1'b1;
                        Done    = 1'b1;
                    end else if (op == OP_MVNZ) begin
                        rout_en = Gnz;
                        rin_en  = Gnz;
                        Done    = 1'b1;
                    end else if (is_alu_op(op)) begin
                        // First operand (Rx) goes to A; Ry follows in T2.
                        rout_sel = rx;
                        rout_en  = 1'b1;
                        Ain      = 1'b1;
                    end else begin
                        Done    = 1'b1;
                    end
                end
                T2: begin
                    rout_en = 1'b1;
                    Gin     = 1'b1;
                    sinal   = OP_W'(op);
                end
                T3: begin
                    Gout   = 1'b1;
                    rin_en = 1'b1;
                    Done   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    dec3to8 u_rin_dec (
        .idx    (rin_sel),
        .en     (rin_en),
        .onehot (Rin)
    );

    dec3to8 u_rout_dec (
        .idx    (rout_sel),
        .en     (rout_en),
        .onehot (Rout)
    );

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multicycle control FSM for the 16-bit bus-based processor. It latches an instruction from DIN, decodes it, and sequences the register-file, A, G and bus-mux strobes.
- It drives the 4-bit operation select (sinal) consumed by the ULA, so it is the issuing end of the ULA interface.
- It sits between the instruction source (DIN/Run) and the datapath (R0..R7, A, G, bus mux).

Parameters:
- DATA_W, 16, instruction/data width.
- OP_W, 4, opcode field width; equals the ULA select width.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  synchronous, active-low reset.
- Run  in  1  start request, sampled only in T0.
- DIN  in  DATA_W  instruction word in T0; immediate data in T1 of mvi.
- Gnz  in  1  1 when the G register is non-zero (used by mvnz).
- sinal  out  OP_W  ULA operation select.
- Rin  out  8  one-hot write enable for R0..R7.
- Rout  out  8  one-hot bus drive for R0..R7.
- Ain  out  1  load A from Bus.
- Gin  out  1  load G from ULA output.
- Gout  out  1  G drives Bus.
- DINout  out  1  DIN drives Bus.
- Done  out  1  one-cycle pulse in the final step of an instruction.

Behaviour:
- Reset
  - Clocking: one clock (Clock). Resetn is synchronous and active-low.
  - On Resetn=0 at a rising edge: state becomes T0 and internal IR becomes 0.
  - While Resetn=0, all outputs are forced to 0 (sinal=4'b0000).
  - Reset mid-instruction aborts the instruction: no Done and no register write.
- Instruction format
  - IR[15:12]=op, IR[11:9]=Rx, IR[8:6]=Ry, IR[5:0] ignored.
- Opcodes
  - 0000 mv Rx<-Ry
  - 0001 mvi Rx<-DIN
  - 0100 mvnz: if Gnz then Rx<-Ry
  - 0101 add, 0110 sub, 0111 or, 1000 slt, 1001 sll, 1010 srl: Rx<-Rx op Ry
  - All other opcodes are illegal and execute as a NOP.
- States: T0, T1, T2, T3. Binary state register; all outputs are decoded from state and IR.
- T0
  - If Run=1, IR<=DIN and next state is T1; otherwise stay in T0.
  - No strobes are asserted in T0.
- T1
  - mv: Rout[Ry], Rin[Rx], Done; next T0.
  - mvi: DINout, Rin[Rx], Done; next T0.
  - mvnz: Done always; Rout[Ry] and Rin[Rx] only if Gnz=1; next T0.
  - ALU op: Rout[Rx], Ain; next T2.
  - Illegal: Done only; next T0.
- T2 (ALU ops only): Rout[Ry], Gin, sinal=IR[15:12]; next T3.
- T3 (ALU ops only): Gout, Rin[Rx], Done; next T0.
- sinal is 4'b0000 in every state except T2.
- Latency
  - mv, mvi, mvnz and illegal: 2 cycles including fetch.
  - ALU ops: 4 cycles.
  - Back-to-back: Run may stay high; the next fetch happens in the cycle after Done.
- Run is ignored in T1..T3.
- DIN is sampled in T0; it is also a bus source in T1 of mvi.
- Bus exclusivity: in every cycle at most one of {Rout bits, Gout, DINout} is 1. Rin and Rout are one-hot or all-zero.
- Rx==Ry is legal: e.g. add R2,R2 reads R2 twice and writes R2 in T3.

Decomposition:
- Shared package control_pkg holds:
  - opcode constants OP_MV, OP_MVI, OP_MVNZ, OP_ADD, OP_SUB, OP_OR, OP_SLT, OP_SLL, OP_SRL (the ALU values must match the ULA select codes);
  - state encoding T0..T3;
  - IR field bit positions.
- One sub-module: dec3to8 (3-bit index to 8-bit one-hot, with enable). It is instantiated twice, for Rin and for Rout.

Test Plan:
- Reset: Resetn=0 for 2 cycles with Run=1 and DIN=16'h5280 -> all outputs 0, no Done; after release, the first T0 loads IR.
- mvi R3: Run=1, DIN=16'h1600 in T0, DIN=16'h00AB in T1 -> T1 shows DINout=1, Rin=8'b0000_1000, Done=1; 2 cycles total.
- add R1,R2 (16'h5280):
  - T1: Rout=8'h02, Ain=1.
  - T2: Rout=8'h04, Gin=1, sinal=4'b0101.
  - T3: Gout=1, Rin=8'h02, Done=1.
  - Repeat with sll R6,R1 (16'h9C40) -> T2 sinal=4'b1001, T3 Rin=8'h40.
- mvnz R4,R5 (16'h4940):
  - Gnz=1 -> T1 Rout=8'h20, Rin=8'h10, Done.
  - Gnz=0 -> only Done, Rin=0.
- Illegal 16'hF000, then mv R0,R7 (16'h01C0) back-to-back with Run held high:
  - F000 -> Done in T1 with no strobes.
  - Next instruction fetched immediately -> T1 Rout=8'h80, Rin=8'h01.
- Reset mid-add: Resetn=0 in T2 -> next cycle state T0, no Gout/Rin/Done; a bus-exclusivity assertion holds for the whole run.
